ram2hex_dump: RTL and testbench
===============================

Name: ram2hex_dump

Overview:
- Read-side companion to the test-harness RAM loader: streams a contiguous address range out of a single-port synchronous-read RAM through its R0 port.
- Presents each word on a valid/ready output stream, tagged with its address, for a bench-side hex writer or comparator.
- Sits beside the RAM macro in the test harness and drives R0_clk/R0_en/R0_addr. The clock is shared with the RAM.

Parameters:
- ADDR_W, 25, RAM address width.
- DATA_W, 128, RAM word width.
- CNT_W, 26, width of word-count input; must be at least ADDR_W+1 so a full-memory dump is expressible.

Ports:
- clk  input  1  clock; also forwarded to R0_clk.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- start  input  1  one-cycle request; sampled only in IDLE.
- base_addr  input  ADDR_W  first address; sampled with start.
- word_count  input  CNT_W  number of words to dump; sampled with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the last word has been accepted downstream.
- R0_clk  output  1  equals clk.
- R0_en  output  1  read enable.
- R0_addr  output  ADDR_W  read address.
- R0_data  input  DATA_W  read data; valid the cycle after R0_en, and held until the next enabled read.
- out_valid  output  1  stream word valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_W  word.
- out_addr  output  ADDR_W  address of out_data.

Behaviour:
- Reset (reset==0 at posedge):
  - State=IDLE.
  - busy=0, done=0, R0_en=0, R0_addr=0, out_valid=0, out_data=0, out_addr=0.
  - Output buffer is flushed and the in-flight flag is cleared.
- Reset mid-dump: the dump is abandoned, no done pulse is produced, and nothing is emitted after reset.
- States: IDLE, RUN, DRAIN.
  - IDLE: on start with word_count!=0, latch base_addr into next_addr and word_count into remaining; go to RUN; busy=1 next cycle.
  - IDLE, start with word_count==0: stay in IDLE; pulse done for one cycle on the next cycle; busy stays 0.
  - start while busy is ignored.
  - RUN: issue a read whenever remaining!=0 and (fifo_count + inflight) < 2. Issuing a read means:
    - R0_en=1, R0_addr=next_addr.
    - next_addr increments modulo 2^ADDR_W; wrap from all-ones to 0 is legal.
    - remaining decrements.
    - inflight is set for the next cycle.
  - RUN -> DRAIN when the last read issues.
  - DRAIN -> IDLE when inflight==0, the FIFO is empty and the last word has been accepted. done=1 in the cycle after that final handshake; busy falls in that same cycle.
- Capture: in the cycle after an issued read, R0_data and its address are pushed into a 2-entry output FIFO.
- Output stream:
  - Emission order equals address order.
  - out_valid=1 whenever the FIFO is non-empty.
  - Data and addr come from the head entry.
  - A pop occurs when out_valid && out_ready.
  - Once asserted, out_valid and the payload stay stable until accepted.
  - A push and a pop in the same cycle are both honoured.
- Throughput: with out_ready held high, one word per cycle after a 2-cycle start-to-first-valid latency (start at cycle 0 -> R0_en at cycle 1 -> out_valid at cycle 2).
- Backpressure: the reservation rule means the FIFO never overflows and a read is never issued without space for its data.
- R0_en=0 in IDLE, in DRAIN, and whenever a read is not issued.

Optional Feature:
- Macro: RAM2HEX_DUMP_CHECKSUM_EN.
- Defined: adds output checksum[DATA_W-1:0].
  - Cleared to 0 on an accepted start and on reset.
  - XOR-accumulates out_data on every stream handshake.
  - Holds its value in IDLE and is valid when done pulses.
- Undefined: the port and its logic are absent; everything else is unchanged.

Test Plan:
- RAM preloaded with ram[a]=a*3; start, base=0x10, count=4, out_ready=1 -> out_addr 0x10..0x13 on cycles 2..5 with data 0x30,0x33,0x36,0x39; done at cycle 6; R0_en high on cycles 1..4 only.
- Same dump with out_ready toggling 1,0,0,1,... -> every word emitted exactly once, in order; payload stable while stalled; R0_en never pushes fifo_count+inflight above 2.
- base=0x1FFFFFE, count=4 -> addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000, 0x0000001.
- count=0 -> no R0_en, no out_valid, done pulses the cycle after start; start pulsed during a busy dump is ignored, and the original count is completed.
- reset driven low for one cycle mid-dump with 2 words buffered -> next cycle out_valid=0, busy=0, no done; a new start then dumps correctly from its own base.
- With RAM2HEX_DUMP_CHECKSUM_EN defined, dump of 4 words 0x30,0x33,0x36,0x39 -> checksum=0x30^0x33^0x36^0x39=0x0C at done.

Source files
------------

// File: rtl/ram2hex_dump.sv
// Streams a contiguous RAM address range out through the R0 read port as an address-tagged valid/ready stream.
// Optional RAM2HEX_DUMP_CHECKSUM_EN adds an XOR checksum of every accepted word.
module ram2hex_dump #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              R0_clk,
    output logic              R0_en,
    output logic [ADDR_W-1:0] R0_addr,
    input  logic [DATA_W-1:0] R0_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef RAM2HEX_DUMP_CHECKSUM_EN
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] checksum
`else
    output logic [ADDR_W-1:0] out_addr
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [ADDR_W-1:0]  r_next_addr;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_inflight_addr;
    logic               r_done;

    logic [DATA_W-1:0]  r_f0_data;
    logic [ADDR_W-1:0]  r_f0_addr;
    logic [DATA_W-1:0]  r_f1_data;
    logic [ADDR_W-1:0]  r_f1_addr;
    logic [1:0]         r_fifo_count;

    logic [1:0]         w_occ;
    logic               w_issue;
    logic               w_pop;
    logic               w_start_run;
    logic               w_start_zero;
    logic               w_last_pop;
    logic               w_done_next;
    logic [DATA_W-1:0]  w_head_data;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [DATA_W-1:0]  w_second_data;
    logic [ADDR_W-1:0]  w_second_addr;

    // The word in flight counts as a queue entry behind the FIFO so that it can be
    // presented straight from R0_data when the FIFO is empty (fall-through).
    always_comb begin
        w_occ         = r_fifo_count + {1'b0, r_inflight};
        w_head_data   = '0;
        w_head_addr   = '0;
        w_second_data = '0;
        w_second_addr = '0;
        if (r_fifo_count != 2'd0) begin
            w_head_data = r_f0_data;
            w_head_addr = r_f0_addr;
        end else if (r_inflight) begin
            w_head_data = R0_data;
            w_head_addr = r_inflight_addr;
        end
        if (r_fifo_count == 2'd2) begin
            w_second_data = r_f1_data;
            w_second_addr = r_f1_addr;
        end else if (r_fifo_count == 2'd1 && r_inflight) begin
            w_second_data = R0_data;
            w_second_addr = r_inflight_addr;
        end
    end

    always_comb begin
        w_start_run  = (r_state == S_IDLE) && start && (word_count != '0);
        w_start_zero = (r_state == S_IDLE) && start && (word_count == '0);
        w_pop        = (w_occ != 2'd0) && out_ready;
        w_issue      = (r_state == S_RUN) && (r_remaining != '0) && (w_occ < 2'd2);
        w_last_pop   = (r_state == S_DRAIN) && w_pop && (w_occ == 2'd1);
        w_done_next  = w_start_zero || w_last_pop;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_run) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_issue && (r_remaining == CNT_W'(1))) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_pop) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_done          <= 1'b0;
            r_next_addr     <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_done     <= w_done_next;
            r_inflight <= w_issue;
            if (w_start_run) begin
                r_next_addr <= base_addr;
                r_remaining <= word_count;
            end else if (w_issue) begin
                r_next_addr <= r_next_addr + ADDR_W'(1);
                r_remaining <= r_remaining - CNT_W'(1);
            end
            if (w_issue) begin
                r_inflight_addr <= r_next_addr;
            end
        end
    end

    // The reservation rule caps fifo_count + inflight at 2, so after a pop at most
    // one entry survives and the shift into slot 0 never loses data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fifo_count <= 2'd0;
            r_f0_data    <= '0;
            r_f0_addr    <= '0;
            r_f1_data    <= '0;
            r_f1_addr    <= '0;
        end else if (w_pop) begin
            r_fifo_count <= w_occ - 2'd1;
            r_f0_data    <= w_second_data;
            r_f0_addr    <= w_second_addr;
        end else begin
            r_fifo_count <= w_occ;
            r_f0_data    <= w_head_data;
            r_f0_addr    <= w_head_addr;
            r_f1_data    <= w_second_data;
            r_f1_addr    <= w_second_addr;
        end
    end

`ifdef RAM2HEX_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_checksum <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum ^ w_head_data;
        end
    end

    assign checksum = r_checksum;
`endif

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign R0_clk    = clk;
    assign R0_en     = w_issue;
    assign R0_addr   = w_issue ? r_next_addr : '0;
    assign out_valid = (w_occ != 2'd0);
    assign out_data  = w_head_data;
    assign out_addr  = w_head_addr;

endmodule

// File: tb/tb_ram2hex_dump.sv
// Directed self-checking bench for ram2hex_dump; the RAM model returns ram[a] = a*3.
// Define RAM2HEX_DUMP_CHECKSUM_EN on both files to also check the checksum output.
module tb_ram2hex_dump;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 26;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic              busy;
    logic              done;
    logic              R0_clk;
    logic              R0_en;
    logic [ADDR_W-1:0] R0_addr;
    logic [DATA_W-1:0] R0_data = '0;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
`ifdef RAM2HEX_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    int passes = 0;
    int checks = 0;

    logic              capEn    [0:15];
    logic              capValid [0:15];
    logic              capDone  [0:15];
    logic              capBusy  [0:15];
    logic [ADDR_W-1:0] capR0Addr[0:15];
    logic [ADDR_W-1:0] capAddr  [0:15];
    logic [DATA_W-1:0] capData  [0:15];
    logic [DATA_W-1:0] capSum   [0:15];

    logic [ADDR_W-1:0] exp1Addr[0:3] = '{25'h10, 25'h11, 25'h12, 25'h13};
    logic [DATA_W-1:0] exp1Data[0:3] = '{128'h30, 128'h33, 128'h36, 128'h39};
    logic [ADDR_W-1:0] exp3Addr[0:3] = '{25'h1FFFFFE, 25'h1FFFFFF, 25'h0, 25'h1};
    logic [DATA_W-1:0] exp3Data[0:3] = '{128'h5FFFFFA, 128'h5FFFFFD, 128'h0, 128'h3};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (R0_en) begin
            R0_data <= DATA_W'(R0_addr) * DATA_W'(3);
        end
    end

    ram2hex_dump #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .word_count(word_count),
        .busy      (busy),
        .done      (done),
        .R0_clk    (R0_clk),
        .R0_en     (R0_en),
        .R0_addr   (R0_addr),
        .R0_data   (R0_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef RAM2HEX_DUMP_CHECKSUM_EN
        .out_addr  (out_addr),
        .checksum  (checksum)
`else
        .out_addr  (out_addr)
`endif
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Pulses start at cycle 0 (and optionally again at injectCyc) and records outputs per cycle.
    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt,
                                 input int ncyc, input int injectCyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            start      = (c == 0) || (c == injectCyc);
            base_addr  = (c == 0) ? base : ADDR_W'(32'h40);
            word_count = (c == 0) ? cnt : CNT_W'(1);
            @(negedge clk);
            capEn[c]     = R0_en;
            capValid[c]  = out_valid;
            capDone[c]   = done;
            capBusy[c]   = busy;
            capR0Addr[c] = R0_addr;
            capAddr[c]   = out_addr;
            capData[c]   = out_data;
`ifdef RAM2HEX_DUMP_CHECKSUM_EN
            capSum[c]    = checksum;
`else
            capSum[c]    = '0;
`endif
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int issued;
        int accepted;
        logic prevStall;
        logic seenDone;

        reset      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst busy",     128'(busy),      128'(0));
        checkOutput("rst done",     128'(done),      128'(0));
        checkOutput("rst R0_en",    128'(R0_en),     128'(0));
        checkOutput("rst R0_addr",  128'(R0_addr),   128'(0));
        checkOutput("rst valid",    128'(out_valid), 128'(0));
        checkOutput("rst out_data", out_data,        128'(0));
        checkOutput("rst out_addr", 128'(out_addr),  128'(0));

        $display("[TB] basic dump base 0x10 count 4");
        applyStimulus(25'h10, 26'd4, 8, -1);
        for (int c = 0; c < 8; c++) begin
            checkOutput($sformatf("t1 en c%0d", c),    128'(capEn[c]),    128'(c >= 1 && c <= 4));
            checkOutput($sformatf("t1 valid c%0d", c), 128'(capValid[c]), 128'(c >= 2 && c <= 5));
            checkOutput($sformatf("t1 done c%0d", c),  128'(capDone[c]),  128'(c == 6));
            checkOutput($sformatf("t1 busy c%0d", c),  128'(capBusy[c]),  128'(c >= 1 && c <= 5));
            if (c >= 1 && c <= 4) begin
                checkOutput($sformatf("t1 R0_addr c%0d", c), 128'(capR0Addr[c]), 128'(exp1Addr[c-1]));
            end
            if (c >= 2 && c <= 5) begin
                checkOutput($sformatf("t1 addr c%0d", c), 128'(capAddr[c]), 128'(exp1Addr[c-2]));
                checkOutput($sformatf("t1 data c%0d", c), capData[c], exp1Data[c-2]);
            end
        end
`ifdef RAM2HEX_DUMP_CHECKSUM_EN
        checkOutput("t1 checksum", capSum[6], 128'h0C);
`endif

        $display("[TB] backpressure dump, ready pattern 1,0,0");
        issued    = 0;
        accepted  = 0;
        prevStall = 1'b0;
        seenDone  = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            start      = (k == 0);
            base_addr  = 25'h10;
            word_count = 26'd4;
            out_ready  = ((k % 3) == 0);
            @(negedge clk);
            if (R0_en) begin
                checkOutput("t2 reserve", 128'((issued - accepted) < 2), 128'(1));
                issued++;
            end
            if (prevStall) begin
                checkOutput("t2 hold valid", 128'(out_valid), 128'(1));
            end
            if (out_valid) begin
                checkOutput("t2 addr", 128'(out_addr), 128'(32'h10 + accepted));
                checkOutput("t2 data", out_data, 128'((32'h10 + accepted) * 3));
                if (out_ready) begin
                    accepted++;
                end
            end
            prevStall = out_valid && !out_ready;
            if (done) begin
                seenDone = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        start     = 1'b0;
        out_ready = 1'b1;
        checkOutput("t2 done seen", 128'(seenDone), 128'(1));
        checkOutput("t2 accepted",  128'(accepted), 128'(4));
        checkOutput("t2 issued",    128'(issued),   128'(4));

        $display("[TB] wrap-around dump");
        applyStimulus(25'h1FFFFFE, 26'd4, 8, -1);
        for (int c = 2; c <= 5; c++) begin
            checkOutput($sformatf("t3 valid c%0d", c), 128'(capValid[c]), 128'(1));
            checkOutput($sformatf("t3 addr c%0d", c),  128'(capAddr[c]),  128'(exp3Addr[c-2]));
            checkOutput($sformatf("t3 data c%0d", c),  capData[c],        exp3Data[c-2]);
        end
        checkOutput("t3 done", 128'(capDone[6]), 128'(1));

        $display("[TB] zero-count start");
        applyStimulus(25'h55, 26'd0, 4, -1);
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("t4 en c%0d", c),    128'(capEn[c]),    128'(0));
            checkOutput($sformatf("t4 valid c%0d", c), 128'(capValid[c]), 128'(0));
            checkOutput($sformatf("t4 busy c%0d", c),  128'(capBusy[c]),  128'(0));
            checkOutput($sformatf("t4 done c%0d", c),  128'(capDone[c]),  128'(c == 1));
        end

        $display("[TB] start while busy is ignored");
        applyStimulus(25'h20, 26'd3, 8, 2);
        for (int c = 0; c < 8; c++) begin
            checkOutput($sformatf("t5 en c%0d", c),    128'(capEn[c]),    128'(c >= 1 && c <= 3));
            checkOutput($sformatf("t5 valid c%0d", c), 128'(capValid[c]), 128'(c >= 2 && c <= 4));
            checkOutput($sformatf("t5 done c%0d", c),  128'(capDone[c]),  128'(c == 5));
            if (c >= 2 && c <= 4) begin
                checkOutput($sformatf("t5 addr c%0d", c), 128'(capAddr[c]), 128'(32'h20 + c - 2));
            end
        end

        $display("[TB] reset in the middle of a dump");
        out_ready = 1'b0;
        applyStimulus(25'h10, 26'd4, 4, -1);
        checkOutput("t6 pre valid", 128'(capValid[3]), 128'(1));
        checkOutput("t6 pre addr",  128'(capAddr[3]),  128'(32'h10));
        checkOutput("t6 pre en",    128'(capEn[3]),    128'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("t6 valid",    128'(out_valid), 128'(0));
        checkOutput("t6 busy",     128'(busy),      128'(0));
        checkOutput("t6 done",     128'(done),      128'(0));
        checkOutput("t6 en",       128'(R0_en),     128'(0));
        checkOutput("t6 out_data", out_data,        128'(0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t6 quiet valid %0d", c), 128'(out_valid), 128'(0));
            checkOutput($sformatf("t6 quiet done %0d", c),  128'(done),      128'(0));
        end
        applyStimulus(25'h30, 26'd2, 6, -1);
        checkOutput("t6 new addr0", 128'(capAddr[2]),  128'(32'h30));
        checkOutput("t6 new data0", capData[2],        128'h90);
        checkOutput("t6 new addr1", 128'(capAddr[3]),  128'(32'h31));
        checkOutput("t6 new data1", capData[3],        128'h93);
        checkOutput("t6 new done",  128'(capDone[4]),  128'(1));
        checkOutput("t6 no extra",  128'(capValid[4]), 128'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
